// File: rtl/gfx256_pkg.sv
// Shared types and constants for the gfx256 render-side Wishbone master.
//   wbm_state_e : request/bus FSM states
//   pend_e      : action to resume once a combining-buffer flush completes
//   LINE_BYTES / LINE_LSB / TAG_W : memory line geometry (32-byte lines)
package gfx256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_READ,
    ST_ACK
  } wbm_state_e;

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_WRITE,
    PEND_READ
  } pend_e;

  localparam int LINE_BYTES = 32;
  localparam int LINE_LSB   = 5;
  localparam int TAG_W      = 32 - LINE_LSB;

endpackage

// File: rtl/gfx256_wc_line.sv
// One-line write-combining register: valid bit, line tag, byte mask, data.
// Ports:
//   clk_i, rst_i      clock, async active-high reset (clears valid/tag/mask)
//   clear_i           invalidate line and clear mask (after a write-back)
//   merge_i           merge dat_i bytes selected by sel_i, load tag_i
//   tag_i/sel_i/dat_i incoming request line tag, byte enables, data
//   valid_o/tag_o/mask_o/data_o  current line contents
//   hit_o             valid and tag_i matches the held tag
// clear_i and merge_i together merge into a freshly emptied line.
module gfx256_wc_line
  import gfx256_pkg::*;
#(
  parameter int MDW = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               merge_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic [MDW/8-1:0]   sel_i,
  input  logic [MDW-1:0]     dat_i,
  output logic               valid_o,
  output logic               hit_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [MDW/8-1:0]   mask_o,
  output logic [MDW-1:0]     data_o
);

  localparam int NB = MDW / 8;

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [NB-1:0]    mask_q;
  logic [MDW-1:0]   data_q, data_d;

  always_comb begin
    data_d = data_q;
    for (int b = 0; b < NB; b++) begin
      if (sel_i[b]) data_d[b*8 +: 8] = dat_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      mask_q  <= '0;
    end else if (merge_i) begin
      valid_q <= 1'b1;
      tag_q   <= tag_i;
      mask_q  <= (clear_i ? '0 : mask_q) | sel_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      mask_q  <= '0;
    end
  end

  // Payload bytes are qualified by mask_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (merge_i) data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign hit_o   = valid_q && (tag_q == tag_i);
  assign tag_o   = tag_q;
  assign mask_o  = mask_q;
  assign data_o  = data_q;

endmodule

// File: rtl/gfx256_render_wbm.sv
// Renderer pixel-request responder with a one-line write-combining buffer,
// issuing 256-bit Wishbone classic cycles to video memory.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   render_addr_i/sel_i/dat_i    pixel request (byte addr, byte enables, data)
//   write_i, read_i              level requests, held until ack_o
//   ack_o, render_dat_o          completion pulse, read data
//   flush_i                      force write-back of a dirty buffer
//   idle_o                       FSM idle and buffer clean
//   m_*                          Wishbone master (line-aligned addresses)
module gfx256_render_wbm
  import gfx256_pkg::*;
#(
  parameter int MDW           = 256,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        render_addr_i,
  input  logic [MDW/8-1:0]   render_sel_i,
  input  logic [MDW-1:0]     render_dat_i,
  input  logic               write_i,
  input  logic               read_i,
  output logic               ack_o,
  output logic [MDW-1:0]     render_dat_o,
  input  logic               flush_i,
  output logic               idle_o,
  output logic               m_cyc_o,
  output logic               m_stb_o,
  output logic               m_we_o,
  output logic [MDW/8-1:0]   m_sel_o,
  output logic [31:0]        m_adr_o,
  output logic [MDW-1:0]     m_dat_o,
  input  logic               m_ack_i,
  input  logic               m_err_i,
  input  logic [MDW-1:0]     m_dat_i
);

  localparam logic [7:0] TMO = 8'(FLUSH_TIMEOUT);

  wbm_state_e state_q, state_d;
  pend_e      pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d;

  logic             line_valid, line_hit, line_merge, line_clear, valid_nx;
  logic [TAG_W-1:0] line_tag;
  logic [MDW/8-1:0] line_mask;
  logic [MDW-1:0]   line_data;
  logic             bus_done;

  logic             cyc_q, stb_q, we_q, ack_q, idle_q;
  logic [MDW/8-1:0] sel_q;
  logic [31:0]      adr_q;
  logic [MDW-1:0]   mdat_q, rdat_q;

  // Byte offset within the line never reaches the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^render_addr_i[LINE_LSB-1:0];

  gfx256_wc_line #(.MDW(MDW)) u_line (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (line_clear),
    .merge_i (line_merge),
    .tag_i   (render_addr_i[31:LINE_LSB]),
    .sel_i   (render_sel_i),
    .dat_i   (render_dat_i),
    .valid_o (line_valid),
    .hit_o   (line_hit),
    .tag_o   (line_tag),
    .mask_o  (line_mask),
    .data_o  (line_data)
  );

  assign bus_done = m_ack_i | m_err_i;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    line_merge = 1'b0;
    line_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (write_i) begin
          if (!line_valid || line_hit) begin
            line_merge = 1'b1;
            state_d    = ST_ACK;
          end else begin
            state_d = ST_FLUSH;
            pend_d  = PEND_WRITE;
          end
        end else if (read_i) begin
          // Reads always drain the buffer first, hit or miss.
          if (line_valid) begin
            state_d = ST_FLUSH;
            pend_d  = PEND_READ;
          end else begin
            state_d = ST_READ;
          end
        end else if (line_valid) begin
          if (flush_i || (cnt_q + 8'd1 == TMO)) begin
            state_d = ST_FLUSH;
            pend_d  = PEND_NONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_FLUSH: begin
        if (bus_done) begin
          line_clear = 1'b1;
          pend_d     = PEND_NONE;
          case (pend_q)
            PEND_WRITE: begin
              // Request is still held stable: merge into the emptied line.
              line_merge = 1'b1;
              state_d    = ST_ACK;
            end
            PEND_READ: state_d = ST_READ;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_READ: begin
        if (bus_done) state_d = ST_ACK;
      end
      ST_ACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign valid_nx = line_merge | (line_valid & ~line_clear);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pend_q  <= PEND_NONE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      mdat_q  <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == ST_ACK);
      idle_q  <= (state_d == ST_IDLE) && !valid_nx;

      // Exit of a bus state first, so a FLUSH->READ handoff re-raises cyc.
      if ((state_q == ST_FLUSH || state_q == ST_READ) && bus_done) begin
        cyc_q <= 1'b0;
        stb_q <= 1'b0;
        we_q  <= 1'b0;
      end
      if (state_q == ST_READ && bus_done) begin
        rdat_q <= m_err_i ? '0 : m_dat_i;
      end
      if (state_q != ST_FLUSH && state_d == ST_FLUSH) begin
        cyc_q  <= 1'b1;
        stb_q  <= 1'b1;
        we_q   <= 1'b1;
        adr_q  <= {line_tag, {LINE_LSB{1'b0}}};
        sel_q  <= line_mask;
        mdat_q <= line_data;
      end
      if (state_q != ST_READ && state_d == ST_READ) begin
        cyc_q <= 1'b1;
        stb_q <= 1'b1;
        we_q  <= 1'b0;
        adr_q <= {render_addr_i[31:LINE_LSB], {LINE_LSB{1'b0}}};
        sel_q <= render_sel_i;
      end
    end
  end

  assign ack_o        = ack_q;
  assign render_dat_o = rdat_q;
  assign idle_o       = idle_q;
  assign m_cyc_o      = cyc_q;
  assign m_stb_o      = stb_q;
  assign m_we_o       = we_q;
  assign m_sel_o      = sel_q;
  assign m_adr_o      = adr_q;
  assign m_dat_o      = mdat_q;

endmodule

// File: tb/tb_gfx256_render_wbm.sv
// Bench for gfx256_render_wbm: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the combining buffer and a
// renderer-visible memory image.
module tb_gfx256_render_wbm;

  localparam int FLUSH_TIMEOUT = 16;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  render_addr_i;
  logic [31:0]  render_sel_i;
  logic [255:0] render_dat_i;
  logic         write_i, read_i, flush_i;
  logic         ack_o, idle_o;
  logic [255:0] render_dat_o;
  logic         m_cyc_o, m_stb_o, m_we_o;
  logic [31:0]  m_sel_o, m_adr_o;
  logic [255:0] m_dat_o;
  logic         m_ack_i, m_err_i;
  logic [255:0] m_dat_i;

  gfx256_render_wbm #(.MDW(256), .FLUSH_TIMEOUT(FLUSH_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .render_addr_i(render_addr_i), .render_sel_i(render_sel_i),
    .render_dat_i(render_dat_i), .write_i(write_i), .read_i(read_i),
    .ack_o(ack_o), .render_dat_o(render_dat_o), .flush_i(flush_i),
    .idle_o(idle_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_dat_i(m_dat_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit           mvalid = 1'b0;
  bit [26:0]    mtag;
  bit [31:0]    mmask = '0;
  bit [255:0]   mdata;
  bit [255:0]   mem  [bit [26:0]];   // contents of video memory
  bit [255:0]   view [bit [26:0]];   // what the renderer should read back

  function automatic bit [255:0] bmask(input bit [31:0] s);
    bit [255:0] r;
    for (int b = 0; b < 32; b++) r[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
    return r;
  endfunction

  function automatic bit [255:0] bmerge(input bit [255:0] o, input bit [255:0] n, input bit [31:0] s);
    return (o & ~bmask(s)) | (n & bmask(s));
  endfunction

  function automatic bit [255:0] mem_get(input bit [26:0] l);
    if (mem.exists(l)) return mem[l];
    return '0;
  endfunction

  function automatic bit [255:0] view_get(input bit [26:0] l);
    if (view.exists(l)) return view[l];
    return '0;
  endfunction

  // ---------------- bus responder ----------------
  int           slv_wait_fixed = -1;
  bit           slv_err = 1'b0;
  bit           slv_ovr = 1'b0;
  logic [255:0] slv_ovr_dat;
  int           seq = 0, bw_cnt = 0, br_cnt = 0, bw_seq = 0, br_seq = 0;
  logic [31:0]  bw_adr, bw_sel;
  logic [255:0] bw_dat;
  logic [31:0]  cur_addr, cur_sel;
  bit           cur_rd;

  task automatic bus_term();
    bit [26:0] l;
    l = m_adr_o[31:5];
    seq++;
    if (m_we_o) begin
      bw_cnt++; bw_seq = seq;
      bw_adr = m_adr_o; bw_sel = m_sel_o; bw_dat = m_dat_o;
      chk("bw_valid", 256'(mvalid), 256'd1);
      chk("bw_adr", 256'(m_adr_o), 256'({mtag, 5'b0}));
      chk("bw_sel", 256'(m_sel_o), 256'(mmask));
      chk("bw_dat", m_dat_o & bmask(m_sel_o), mdata & bmask(mmask));
      if (!slv_err) mem[l] = bmerge(mem_get(l), m_dat_o, m_sel_o);
      mvalid = 1'b0; mmask = '0;
    end else begin
      br_cnt++; br_seq = seq;
      chk("br_clean", 256'(mvalid), 256'd0);
      chk("br_req", 256'(cur_rd), 256'd1);
      chk("br_adr", 256'(m_adr_o), 256'({cur_addr[31:5], 5'b0}));
      chk("br_sel", 256'(m_sel_o), 256'(cur_sel));
      m_dat_i = slv_ovr ? slv_ovr_dat : mem_get(l);
    end
    if (slv_err) m_err_i = 1'b1; else m_ack_i = 1'b1;
  endtask

  initial begin
    int wc;
    wc = -1;
    m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = '0;
    forever begin
      @(negedge clk_i);
      if (m_ack_i || m_err_i) begin
        m_ack_i = 1'b0; m_err_i = 1'b0; wc = -1;
      end else if (m_cyc_o && m_stb_o && !rst_i) begin
        if (wc < 0) wc = (slv_wait_fixed >= 0) ? slv_wait_fixed : int'($urandom_range(0, 3));
        if (wc == 0) begin bus_term(); wc = -1; end
        else wc--;
      end else begin
        wc = -1;
      end
    end
  end

  // ---------------- renderer side ----------------
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] s, input logic [255:0] d);
    cur_addr = a; cur_sel = s; cur_rd = !wr;
    render_addr_i = a; render_sel_i = s; render_dat_i = d;
    write_i = wr; read_i = !wr;
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!ack_o && n < 5000);
    chk("ack_seen", 256'(ack_o), 256'd1);
  endtask

  task automatic post_ack(input bit wr, input logic [31:0] a, input logic [31:0] s,
                          input logic [255:0] d, input bit auto_chk, input logic [255:0] rd);
    bit [26:0] l;
    l = a[31:5];
    if (wr) begin
      chk("wr_miss_flushed", 256'(mvalid && mtag != l), 256'd0);
      if (!mvalid) begin mvalid = 1'b1; mmask = '0; end
      mtag  = l;
      mdata = bmerge(mdata, d, s);
      mmask = mmask | s;
      view[l] = bmerge(view_get(l), d, s);
    end else begin
      chk("rd_flushed", 256'(mvalid), 256'd0);
      if (auto_chk) chk("rd_data", rd, view_get(l));
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] s,
                        input logic [255:0] d, input bit auto_chk, output logic [255:0] rd);
    @(negedge clk_i);
    issue(wr, a, s, d);
    wait_ack();
    write_i = 1'b0; read_i = 1'b0;
    rd = render_dat_o;
    post_ack(wr, a, s, d, auto_chk, rd);
    @(negedge clk_i);
    chk("ack_pulse", 256'(ack_o), 256'd0);
  endtask

  task automatic pulse_flush();
    @(negedge clk_i); flush_i = 1'b1;
    @(negedge clk_i); flush_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(idle_o && !m_cyc_o) && n < 2000) begin @(negedge clk_i); n++; end
    chk("idle_reached", 256'(idle_o), 256'd1);
  endtask

  initial begin
    logic [255:0] rd, d;
    logic [31:0]  a, s;
    bit [26:0]    pool [4];
    int n, b0, saw;
    pool[0] = 27'h80; pool[1] = 27'h81; pool[2] = 27'h100; pool[3] = 27'h3ABCD;
    rst_i = 1'b1; flush_i = 1'b0; write_i = 1'b0; read_i = 1'b0;
    render_addr_i = '0; render_sel_i = '0; render_dat_i = '0;
    cur_addr = '0; cur_sel = '0; cur_rd = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state
    chk("rst_idle", 256'(idle_o), 256'd1);
    chk("rst_ack", 256'(ack_o), 256'd0);
    chk("rst_cyc", 256'({m_cyc_o, m_stb_o, m_we_o}), 256'd0);
    chk("rst_adr", 256'(m_adr_o), 256'd0);
    chk("rst_sel", 256'(m_sel_o), 256'd0);
    chk("rst_rdat", render_dat_o, 256'd0);

    // Single write, then automatic timeout flush
    b0 = bw_cnt;
    do_req(1'b1, 32'h1000, 32'h0000_000F, 256'hAABBCCDD, 1'b0, rd);
    chk("t1_dirty", 256'(idle_o), 256'd0);
    n = 1;
    while (!m_cyc_o && n < 100) begin @(negedge clk_i); n++; end
    chk("t1_tmo_latency", 256'(n), 256'(FLUSH_TIMEOUT + 1));
    wait_idle();
    chk("t1_bw_count", 256'(bw_cnt - b0), 256'd1);
    chk("t1_bw_adr", 256'(bw_adr), 256'h1000);
    chk("t1_bw_sel", 256'(bw_sel), 256'hF);
    chk("t1_bw_dat", 256'(bw_dat[31:0]), 256'hAABBCCDD);

    // Two held-back-to-back writes into one line, then flush_i
    b0 = bw_cnt;
    @(negedge clk_i);
    issue(1'b1, 32'h1000, 32'h0000_000F, 256'hAABBCCDD);
    wait_ack();
    post_ack(1'b1, 32'h1000, 32'h0000_000F, 256'hAABBCCDD, 1'b0, rd);
    issue(1'b1, 32'h1004, 32'h0000_00F0, {192'd0, 32'h11223344, 32'd0});
    wait_ack();
    write_i = 1'b0;
    post_ack(1'b1, 32'h1004, 32'h0000_00F0, {192'd0, 32'h11223344, 32'd0}, 1'b0, rd);
    chk("t2_no_early_bw", 256'(bw_cnt - b0), 256'd0);
    pulse_flush();
    wait_idle();
    chk("t2_bw_count", 256'(bw_cnt - b0), 256'd1);
    chk("t2_bw_sel", 256'(bw_sel), 256'hFF);
    chk("t2_bw_dat", 256'(bw_dat[63:0]), 256'h11223344_AABBCCDD);

    // Write miss flushes the old line before acknowledging
    do_req(1'b1, 32'h1000, 32'hFFFF_0000, {8{32'h0BADF00D}}, 1'b0, rd);
    b0 = bw_cnt;
    do_req(1'b1, 32'h2000, 32'h0000_0003, {8{32'h12345678}}, 1'b0, rd);
    chk("t3_miss_bw", 256'(bw_cnt - b0), 256'd1);
    chk("t3_miss_adr", 256'(bw_adr), 256'h1000);
    pulse_flush();
    wait_idle();
    chk("t3_new_tag", 256'(bw_adr), 256'h2000);

    // Read with dirty buffer: flush, then delayed read
    do_req(1'b1, 32'h1000, 32'h0000_0001, 256'h77, 1'b0, rd);
    slv_wait_fixed = 3; slv_ovr = 1'b1; slv_ovr_dat = {32{8'h55}};
    b0 = bw_cnt;
    do_req(1'b0, 32'h1000, 32'hFFFF_FFFF, 256'd0, 1'b0, rd);
    chk("t4_rdat", rd, {32{8'h55}});
    chk("t4_flush_first", 256'(bw_cnt - b0 == 1 && bw_seq < br_seq), 256'd1);
    slv_wait_fixed = -1; slv_ovr = 1'b0;

    // Reset while a flush waits for its acknowledge
    do_req(1'b1, 32'h3000, 32'h0000_FF00, {8{32'hCAFEBABE}}, 1'b0, rd);
    slv_wait_fixed = 1000;
    pulse_flush();
    n = 0;
    while (!m_cyc_o && n < 50) begin @(negedge clk_i); n++; end
    chk("t5_flush_started", 256'({m_cyc_o, m_we_o}), 256'd3);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_cyc_async", 256'({m_cyc_o, m_stb_o, m_we_o}), 256'd0);
    chk("t5_idle_async", 256'(idle_o), 256'd1);
    mvalid = 1'b0; mmask = '0;
    view = mem;
    slv_wait_fixed = -1;
    b0 = bw_cnt;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    saw = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (m_cyc_o || ack_o || !idle_o) saw++;
    end
    chk("t5_quiet_after_rst", 256'(saw), 256'd0);
    chk("t5_no_bw", 256'(bw_cnt - b0), 256'd0);

    // Read terminated by bus error, then normal traffic
    do_req(1'b0, 32'h1000, 32'hFFFF_FFFF, 256'd0, 1'b1, rd);
    slv_err = 1'b1;
    do_req(1'b0, 32'h4000, 32'hFFFF_FFFF, 256'd0, 1'b0, rd);
    chk("t6_err_rdat", rd, 256'd0);
    slv_err = 1'b0;
    do_req(1'b1, 32'h4000, 32'h8000_0001, {32'h9ABCDEF0, 192'd0, 32'h13579BDF}, 1'b0, rd);
    do_req(1'b0, 32'h4000, 32'hFFFF_FFFF, 256'd0, 1'b1, rd);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      a = {pool[$urandom_range(0, 3)], 5'($urandom)};
      s = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      do_req($urandom_range(0, 3) != 0, a, s, d, 1'b1, rd);
      n = $urandom_range(0, 22);
      for (int g = 0; g < n; g++) begin
        flush_i = ($urandom_range(0, 15) == 0);
        @(negedge clk_i);
      end
      flush_i = 1'b0;
    end
    pulse_flush();
    wait_idle();
    chk("final_clean", 256'(mvalid), 256'd0);
    for (int i = 0; i < 4; i++) chk("final_mem", mem_get(pool[i]), view_get(pool[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
